led_sequencer: RTL and testbench

- Parametrised, registered successor to the front-panel LED index decoder.
- Drives NLED LEDs from a latched index and mode: static one-hot/all-on decode, blinking decode, free-running chase, or bounce.
- Has an internal tick prescaler, so animation needs no external timebase.
- Keeps the active-high `pulse` blanking input.
- Sits between game/control FSMs and the board LED pins.

---
 rtl/led_sequencer.sv | 141 ++++++++++++++
 tb/tb_led_sequencer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/led_sequencer.sv
// led_sequencer: registered LED driver with a built-in animation timebase.
// Latches an index and a mode on a load strobe and drives NLED LEDs as a
// static decode, a blinking decode, a wrapping chase or a ping-pong bounce.
// l[NLED-1] is LED index 0.
module led_sequencer #(
  parameter int unsigned NLED = 6,
  parameter int unsigned IDXW = 7,
  parameter logic [31:0] DIV  = 32'd25000000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [IDXW-1:0] n,
  input  logic [1:0]      mode,
  input  logic            load,
  input  logic            pulse,
  output logic [NLED-1:0] l,
  output logic            tick
);

  typedef enum logic [1:0] {
    MODE_DIRECT = 2'd0,
    MODE_BLINK  = 2'd1,
    MODE_CHASE  = 2'd2,
    MODE_BOUNCE = 2'd3
  } mode_t;

  typedef enum logic {DIR_DOWN = 1'b0, DIR_UP = 1'b1} dir_t;
  typedef enum logic {PH_ON = 1'b0, PH_OFF = 1'b1} phase_t;

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NLED - 1);
  localparam logic [IDXW-1:0] ALL_IDX  = IDXW'(NLED);
  localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(1);

  logic [31:0]     cnt_q, cnt_d;
  logic            tick_q;
  logic [IDXW-1:0] n_q, n_d;
  mode_t           mode_q, mode_d;
  logic [IDXW-1:0] pos_q, pos_d;
  dir_t            dir_q, dir_d;
  phase_t          phase_q, phase_d;
  logic [NLED-1:0] l_q;
  logic [NLED-1:0] next_l;
  logic [NLED-1:0] dec_n;
  logic [NLED-1:0] dec_pos;
  logic            tick_int;

  // Decoders: bit NLED-1-k lights for index k; index NLED lights everything.
  // pos never reaches NLED, so its decoder only needs the one-hot term.
  for (genvar gi = 0; gi < NLED; gi++) begin : g_dec
    assign dec_n[gi]   = (n_q == IDXW'(NLED - 1 - gi)) || (n_q == ALL_IDX);
    assign dec_pos[gi] = (pos_q == IDXW'(NLED - 1 - gi));
  end

  // Next-state logic: prescaler, latched controls and animation stepping.
  // A load overrides a coincident tick so the restart is always clean.
  always_comb begin
    tick_int = (cnt_q == (DIV - 32'd1));
    cnt_d    = tick_int ? 32'd0 : cnt_q + 32'd1;
    n_d      = n_q;
    mode_d   = mode_q;
    pos_d    = pos_q;
    dir_d    = dir_q;
    phase_d  = phase_q;
    if (load) begin
      cnt_d   = 32'd0;
      n_d     = n;
      mode_d  = mode_t'(mode);
      pos_d   = (n < ALL_IDX) ? n : '0;
      dir_d   = DIR_DOWN;
      phase_d = PH_ON;
    end else if (tick_int) begin
      case (mode_q)
        MODE_BLINK: phase_d = (phase_q == PH_ON) ? PH_OFF : PH_ON;
        MODE_CHASE: pos_d = (pos_q >= LAST_IDX) ? '0 : pos_q + IDX_ONE;
        MODE_BOUNCE: begin
          if (NLED > 1) begin
            if (dir_q == DIR_DOWN) begin
              if (pos_q >= LAST_IDX) begin
                // Only reachable when loaded at the far end: turn straight back.
                pos_d = pos_q - IDX_ONE;
                dir_d = DIR_UP;
              end else begin
                pos_d = pos_q + IDX_ONE;
                if ((pos_q + IDX_ONE) == LAST_IDX) dir_d = DIR_UP;
              end
            end else begin
              if (pos_q == '0) begin
                pos_d = IDX_ONE;
                dir_d = DIR_DOWN;
              end else begin
                pos_d = pos_q - IDX_ONE;
                if (pos_q == IDX_ONE) dir_d = DIR_DOWN;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Output pattern selected by the latched mode.
  always_comb begin
    next_l = '0;
    case (mode_q)
      MODE_DIRECT: next_l = dec_n;
      MODE_BLINK:  next_l = (phase_q == PH_ON) ? dec_n : '0;
      MODE_CHASE:  next_l = dec_pos;
      MODE_BOUNCE: next_l = dec_pos;
      default:     next_l = '0;
    endcase
  end

  // State and output registers; reset leaves a blank display in DIRECT mode.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      tick_q  <= 1'b0;
      n_q     <= '1;
      mode_q  <= MODE_DIRECT;
      pos_q   <= '0;
      dir_q   <= DIR_DOWN;
      phase_q <= PH_ON;
      l_q     <= '0;
    end else begin
      cnt_q   <= cnt_d;
      tick_q  <= tick_int;
      n_q     <= n_d;
      mode_q  <= mode_d;
      pos_q   <= pos_d;
      dir_q   <= dir_d;
      phase_q <= phase_d;
      // Blanking only masks the pins; the animation keeps running underneath.
      l_q     <= pulse ? '0 : next_l;
    end
  end

  assign l    = l_q;
  assign tick = tick_q;

endmodule

// File: tb/tb_led_sequencer.sv
// Bench for led_sequencer: two instances (DIV=4 and DIV=2) share stimulus.
// Expected values are queued with their due edge when stimulus is driven
// and compared by a monitor shortly after each rising edge.
module tb_led_sequencer;

  typedef struct {
    int         due;
    int         sel;
    logic [5:0] exp_l;
    logic       chk_tick;
    logic       exp_tick;
    string      tag;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load = 1'b0;
  logic       pulse = 1'b0;
  logic [6:0] n = '0;
  logic [1:0] mode = '0;
  logic [5:0] l4, l2;
  logic       tick4, tick2;

  int   edge_cnt = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  exp_t sb_q[$];

  led_sequencer #(.NLED(6), .IDXW(7), .DIV(32'd4)) u_dut4 (
    .clk(clk), .rst(rst), .n(n), .mode(mode), .load(load), .pulse(pulse),
    .l(l4), .tick(tick4)
  );

  led_sequencer #(.NLED(6), .IDXW(7), .DIV(32'd2)) u_dut2 (
    .clk(clk), .rst(rst), .n(n), .mode(mode), .load(load), .pulse(pulse),
    .l(l2), .tick(tick2)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, edge_cnt);
  endtask

  function automatic logic [5:0] dec(input int k);
    logic [5:0] v;
    v = 6'b100000;
    if (k < 6) return v >> k;
    else if (k == 6) return 6'b111111;
    else return 6'b000000;
  endfunction

  task automatic push_exp(input int due, input int sel, input logic [5:0] el,
                          input logic ct, input logic et, input string tag);
    exp_t e;
    e.due = due; e.sel = sel; e.exp_l = el; e.chk_tick = ct; e.exp_tick = et; e.tag = tag;
    sb_q.push_back(e);
  endtask

  // Drives a load strobe for the coming edge; returns that edge's number.
  task automatic start_load(input int nv, input int mv, output int e);
    @(negedge clk);
    e = edge_cnt + 1;
    n = 7'(nv);
    mode = 2'(mv);
    load = 1'b1;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb_q.size() > 0 && t < 200) begin
      @(negedge clk);
      load = 1'b0;
      t++;
    end
    if (sb_q.size() > 0) begin
      check_eq("drain_timeout", 64'(sb_q.size()), 64'd0);
      sb_q.delete();
    end
  endtask

  // Monitor: compare every expectation that falls due at this edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      while (sb_q.size() > 0 && sb_q[0].due <= edge_cnt) begin
        e = sb_q.pop_front();
        if (e.due < edge_cnt) begin
          check_eq({e.tag, "_late"}, 64'(edge_cnt), 64'(e.due));
        end else begin
          $display("edge %0d %s dut%0d: l=%b tick=%b", edge_cnt, e.tag,
                   (e.sel == 0) ? 4 : 2, (e.sel == 0) ? l4 : l2,
                   (e.sel == 0) ? tick4 : tick2);
          check_eq({e.tag, "_l"}, 64'((e.sel == 0) ? l4 : l2), 64'(e.exp_l));
          if (e.chk_tick)
            check_eq({e.tag, "_tick"}, 64'((e.sel == 0) ? tick4 : tick2), 64'(e.exp_tick));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int e;
    int r;
    int k;
    logic [5:0] prev;
    int t1_n[4] = '{0, 5, 6, 9};
    int bp[13] = '{0, 1, 2, 3, 4, 5, 4, 3, 2, 1, 0, 1, 2};

    // Reset state on both instances.
    for (int i = 1; i <= 3; i++) begin
      push_exp(i, 0, 6'b0, 1'b1, 1'b0, "reset");
      push_exp(i, 1, 6'b0, 1'b1, 1'b0, "reset");
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    drain();

    // DIRECT decode: one-hot, last LED, all-on, out-of-range; two-edge latency.
    prev = 6'b0;
    for (int i = 0; i < 4; i++) begin
      start_load(t1_n[i], 0, e);
      push_exp(e, 0, prev, 1'b0, 1'b0, "direct_hold");
      push_exp(e + 1, 0, dec(t1_n[i]), 1'b0, 1'b0, "direct");
      push_exp(e + 2, 0, dec(t1_n[i]), 1'b0, 1'b0, "direct");
      prev = dec(t1_n[i]);
      drain();
    end

    // BLINK n=2: 4 cycles on, 4 off; tick every 4 cycles.
    start_load(2, 1, e);
    for (int off = 1; off <= 16; off++) begin
      k = (off - 1) / 4;
      push_exp(e + off, 0, (k % 2 == 0) ? dec(2) : 6'b0, 1'b1, (off % 4 == 0), "blink");
    end
    drain();

    // CHASE from n=4: 4,5 then wrap to 0,1.
    start_load(4, 2, e);
    for (int off = 1; off <= 16; off++)
      push_exp(e + off, 0, dec((4 + (off - 1) / 4) % 6), 1'b1, (off % 4 == 0), "chase");
    drain();

    // BOUNCE on the DIV=2 instance: ends held one tick each.
    start_load(0, 3, e);
    for (int off = 1; off <= 24; off++)
      push_exp(e + off, 1, dec(bp[(off - 1) / 2]), 1'b1, (off % 2 == 0), "bounce");
    drain();

    // CHASE with pulse high for edges e+3..e+12; animation keeps time.
    start_load(0, 2, e);
    for (int off = 1; off <= 24; off++)
      push_exp(e + off, 0, (off >= 3 && off <= 12) ? 6'b0 : dec(((off - 1) / 4) % 6),
               1'b0, 1'b0, "pulse");
    for (int j = 1; j <= 14; j++) begin
      @(negedge clk);
      load = 1'b0;
      pulse = (j >= 3 && j <= 12);
    end
    drain();

    // Reset mid-BOUNCE at edge e+7: blank output, prescaler restarts.
    start_load(0, 3, e);
    r = e + 7;
    push_exp(e + 6, 1, dec(bp[(6 - 1) / 2]), 1'b0, 1'b0, "midbounce");
    push_exp(r, 0, 6'b0, 1'b1, 1'b0, "rst_mid");
    push_exp(r, 1, 6'b0, 1'b1, 1'b0, "rst_mid");
    for (int d = 1; d <= 4; d++) begin
      push_exp(r + d, 0, 6'b0, 1'b1, (d == 4), "post_rst");
      if (d <= 2) push_exp(r + d, 1, 6'b0, 1'b1, (d == 2), "post_rst");
    end
    for (int j = 1; j <= 8; j++) begin
      @(negedge clk);
      load = 1'b0;
      rst = (j == 7);
    end
    drain();

    // Load coinciding with tick: load wins, pos = loaded n, cnt restarts.
    start_load(0, 2, e);
    for (int off = 1; off <= 12; off++) begin
      if (off <= 4)
        push_exp(e + off, 0, dec(0), (off < 4), 1'b0, "ldtick_pre");
      else if (off <= 8)
        push_exp(e + off, 0, dec(3), 1'b1, (off == 8), "ldtick_load");
      else
        push_exp(e + off, 0, dec(4), 1'b0, 1'b0, "ldtick_next");
    end
    for (int j = 1; j <= 5; j++) begin
      @(negedge clk);
      if (j == 4) begin
        n = 7'd3;
        mode = 2'd2;
        load = 1'b1;
      end else begin
        load = 1'b0;
      end
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
